// File: rtl/edge_packer.sv
// ============================================================================
//  Module   : edge_packer
//  Purpose  : Output stage behind the hysteresis stage. It packs the serial
//             edge bit stream into WORD_W-bit words, with the first pixel in
//             bit 0. It buffers the words in a small FIFO and presents them
//             to the host on a valid/ready interface. It also counts pixels
//             per frame and pulses frame_done once every word of the frame
//             has been accepted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       system clock, rising edge
//    reset      in   1       synchronous, active-high reset
//    edge_in    in   1       edge decision bit
//    edge_valid in   1       strobe; edge_in is sampled when high
//    out_data   out  WORD_W  packed edge word (first pixel in bit 0)
//    out_valid  out  1       out_data holds a valid word
//    out_ready  in   1       host accepts when out_valid && out_ready
//    frame_done out  1       one-cycle pulse after the frame is drained
//    overflow   out  1       sticky error flag, cleared only by reset
//    pix_count  out  9       pixels sampled so far in the current frame
// ============================================================================
`default_nettype none

module edge_packer #(
    parameter int WORD_W     = 8,
    parameter int FRAME_PIX  = 400,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              edge_in,
    input  logic              edge_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              overflow,
    output logic [8:0]        pix_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [BW-1:0] c_last_bit = BW'(WORD_W - 1);
    localparam logic [BW-1:0] c_bit_one  = BW'(1);
    localparam logic [8:0]    c_last_pix = 9'(FRAME_PIX - 1);
    localparam logic [AW:0]   c_ptr_one  = (AW + 1)'(1);

    // ------------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic [8:0]        r_pix;
    logic              r_overflow;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    // One extra pointer bit tells a full FIFO apart from an empty one.
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;

    // ------------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------------
    logic              w_sample;     // accept the incoming bit this cycle
    logic              w_drop_in;    // incoming bit arrives outside COLLECT
    logic              w_done;       // frame_done pulse
    logic              w_last_pix;   // the bit being sampled ends the frame
    logic              w_push;       // a word completes this cycle
    logic              w_pop;        // host handshake this cycle
    logic              w_empty;
    logic              w_full;
    logic              w_wr_en;      // completed word is stored
    logic              w_push_drop;  // completed word lost to a full FIFO
    logic [WORD_W-1:0] w_word;       // shift register with the new bit merged

    // ------------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------------
    always_comb begin
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_drop_in   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_sample = edge_valid;
                if (edge_valid && (r_pix == c_last_pix)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The frame is finished only once the host has taken the
                // last word. A bit arriving now has no frame to belong to.
                w_drop_in = edge_valid;
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_drop_in   = edge_valid;
                w_done      = 1'b1;
                w_state_nxt = ST_COLLECT;
            end
            default: begin
                w_state_nxt = ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Packing decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WORD_W; i++) begin
            if (BW'(i) == r_bit_cnt) begin
                w_word[i] = edge_in;
            end
        end
        w_last_pix = (r_pix == c_last_pix);
        // The shift register is cleared after every word. A short final
        // word therefore comes out zero-padded in its upper bits.
        w_push      = w_sample && ((r_bit_cnt == c_last_bit) || w_last_pix);
        w_pop       = !w_empty && out_ready;
        // When the FIFO is full, a same-cycle pop frees the slot that is
        // being written. The head word is read out before the clock edge.
        w_wr_en     = w_push && (!w_full || w_pop);
        w_push_drop = w_push && w_full && !w_pop;
    end

    // ------------------------------------------------------------------------
    // Packer, pixel counter, FIFO storage and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_pix      <= '0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_sample) begin
                // Counters advance even when the word is dropped, so the
                // frame stays aligned.
                if (w_push) begin
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_shift   <= w_word;
                    r_bit_cnt <= r_bit_cnt + c_bit_one;
                end
                r_pix <= w_last_pix ? 9'd0 : (r_pix + 9'd1);
            end

            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_word;
                r_wr_ptr                <= r_wr_ptr + c_ptr_one;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            if (w_drop_in || w_push_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The head entry is only rewritten once it has been popped. out_data
    // therefore holds steady while the host stalls.
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign out_valid  = !w_empty;
    assign frame_done = w_done;
    assign overflow   = r_overflow;
    assign pix_count  = r_pix;

endmodule

`default_nettype wire

// File: tb/tb_edge_packer.sv
// ============================================================================
//  Module   : tb_edge_packer
//  Purpose  : Directed, self-checking bench for edge_packer. It uses a
//             default instance (400-pixel frame) and a 20-pixel instance
//             to cover the short final word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edge_packer;

    logic       clk;
    logic       reset;

    // Default instance
    logic       edge_in;
    logic       edge_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_done;
    logic       overflow;
    logic [8:0] pix_count;

    // 20-pixel instance
    logic       e20_in;
    logic       e20_valid;
    logic       e20_ready;
    logic [7:0] e20_data;
    logic       e20_out_valid;
    logic       e20_done;
    logic       e20_overflow;
    logic [8:0] e20_pix;

    int n_checks = 0;
    int n_errors = 0;

    // Handshake and frame_done recorder for the default instance
    int cyc      = 0;
    int hs_cnt   = 0;
    int hs_bad   = 0;
    int hs_cyc   = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    edge_packer #(
        .WORD_W     (8),
        .FRAME_PIX  (400),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .edge_in    (edge_in),
        .edge_valid (edge_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overflow   (overflow),
        .pix_count  (pix_count)
    );

    edge_packer #(
        .WORD_W     (8),
        .FRAME_PIX  (20),
        .FIFO_DEPTH (4)
    ) u_dut20 (
        .clk        (clk),
        .reset      (reset),
        .edge_in    (e20_in),
        .edge_valid (e20_valid),
        .out_data   (e20_data),
        .out_valid  (e20_out_valid),
        .out_ready  (e20_ready),
        .frame_done (e20_done),
        .overflow   (e20_overflow),
        .pix_count  (e20_pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: record any handshake about to happen, then step to 1 ns
    // past the rising edge.
    task automatic tick();
        if (out_valid && out_ready) begin
            hs_cnt++;
            hs_cyc = cyc;
            if (out_data !== 8'hFF) hs_bad++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        out_ready  = 1'b0;
        edge_valid = 1'b0;
        e20_valid  = 1'b0;
        e20_ready  = 1'b0;
        reset      = 1'b1;
        tick();
        tick();
        reset      = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        edge_in    = b;
        edge_valid = 1'b1;
        tick();
        edge_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    // Check the head word, stall one cycle and check that it holds, then pop.
    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        out_ready = 1'b0;
        tick();
        check_eq({tag, "_stall"}, {24'd0, out_data}, {24'd0, exp});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] v_e5;
        v_e5    = 8'hE5;
        edge_in = 1'b0;
        e20_in  = 1'b0;
        do_reset();

        // ---------------- reset state ----------------
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_data", {24'd0, out_data}, 32'd0);
        check_eq("rst_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_pix", {23'd0, pix_count}, 32'd0);

        // ---------------- basic packing: 1,0,1,1,0,0,0,1 -> 8D ----------------
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(0); send_bit(0); send_bit(0);
        check_eq("pk_valid_7", {31'd0, out_valid}, 32'd0);
        send_bit(1);
        check_eq("pk_valid_8", {31'd0, out_valid}, 32'd1);
        check_eq("pk_data", {24'd0, out_data}, 32'h8D);
        check_eq("pk_pix", {23'd0, pix_count}, 32'd8);

        // ---------------- full 400-pixel frame, all ones ----------------
        do_reset();
        hs_cnt = 0; hs_bad = 0; done_cnt = 0; hs_cyc = 0; done_cyc = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) send_bit(1);
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        check_eq("frm_words", hs_cnt, 50);
        check_eq("frm_bad_words", hs_bad, 0);
        check_eq("frm_done_cnt", done_cnt, 1);
        check_eq("frm_done_lat", done_cyc - hs_cyc, 2);
        check_eq("frm_ovf", {31'd0, overflow}, 32'd0);
        check_eq("frm_pix", {23'd0, pix_count}, 32'd0);

        // ---------------- 20-pixel frame: FF, FF, 0F ----------------
        do_reset();
        e20_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            e20_valid = 1'b1;
            tick();
        end
        e20_valid = 1'b0;
        check_eq("f20_pix", {23'd0, e20_pix}, 32'd0);
        check_eq("f20_ovf0", {31'd0, e20_overflow}, 32'd0);
        // A bit arriving during DRAIN is dropped and flags overflow.
        e20_valid = 1'b1;
        tick();
        e20_valid = 1'b0;
        check_eq("f20_ovf_drain", {31'd0, e20_overflow}, 32'd1);
        check_eq("f20_pix_drain", {23'd0, e20_pix}, 32'd0);
        check_eq("f20_w0", {24'd0, e20_data}, 32'hFF);
        e20_ready = 1'b1;
        tick();
        check_eq("f20_w1", {24'd0, e20_data}, 32'hFF);
        tick();
        check_eq("f20_w2", {24'd0, e20_data}, 32'h0F);
        check_eq("f20_done_early", {31'd0, e20_done}, 32'd0);
        tick();
        e20_ready = 1'b0;
        check_eq("f20_empty", {31'd0, e20_out_valid}, 32'd0);
        check_eq("f20_drain_done", {31'd0, e20_done}, 32'd0);
        tick();
        check_eq("f20_done", {31'd0, e20_done}, 32'd1);
        tick();
        check_eq("f20_done_end", {31'd0, e20_done}, 32'd0);
        e20_valid = 1'b1;
        tick();
        e20_valid = 1'b0;
        check_eq("f20_collect", {23'd0, e20_pix}, 32'd1);

        // ---------------- full FIFO with simultaneous push and pop ----------------
        do_reset();
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        check_eq("pp_ovf0", {31'd0, overflow}, 32'd0);
        check_eq("pp_head", {24'd0, out_data}, 32'hA1);
        for (int i = 0; i < 7; i++) send_bit(v_e5[i]);
        out_ready = 1'b1;
        send_bit(v_e5[7]);
        out_ready = 1'b0;
        check_eq("pp_ovf1", {31'd0, overflow}, 32'd0);
        pop_expect("pp_b2", 8'hB2);
        pop_expect("pp_c3", 8'hC3);
        pop_expect("pp_d4", 8'hD4);
        pop_expect("pp_e5", 8'hE5);
        check_eq("pp_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- overflow with stalled host ----------------
        do_reset();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        check_eq("of_ovf_4", {31'd0, overflow}, 32'd0);
        send_byte(8'h55);
        check_eq("of_ovf_5", {31'd0, overflow}, 32'd1);
        check_eq("of_pix", {23'd0, pix_count}, 32'd40);
        pop_expect("of_11", 8'h11);
        pop_expect("of_22", 8'h22);
        pop_expect("of_33", 8'h33);
        pop_expect("of_44", 8'h44);
        check_eq("of_empty", {31'd0, out_valid}, 32'd0);
        check_eq("of_sticky", {31'd0, overflow}, 32'd1);

        // ---------------- reset mid-frame ----------------
        out_ready = 1'b1;
        for (int i = 41; i <= 123; i++) begin
            if (i == 108) out_ready = 1'b0;
            send_bit(0);
        end
        check_eq("mr_pix", {23'd0, pix_count}, 32'd123);
        check_eq("mr_valid", {31'd0, out_valid}, 32'd1);
        check_eq("mr_ovf", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mr_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mr_rst_pix", {23'd0, pix_count}, 32'd0);
        check_eq("mr_rst_ovf", {31'd0, overflow}, 32'd0);
        send_byte(8'h8D);
        check_eq("mr_new_data", {24'd0, out_data}, 32'h8D);
        check_eq("mr_new_pix", {23'd0, pix_count}, 32'd8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/edge_packer.md
Name: edge_packer

Overview:
- Output stage directly downstream of the hysteresis stage of the edge-detection chip.
- Consumes the serial edge bit stream (edge bit plus readable strobe) and packs it into WORD_W-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready interface to the host.
- Counts pixels per frame and signals frame completion once every word of the frame has been accepted.

Parameters:
WORD_W, 8, bits per output word
FRAME_PIX, 400, edge pixels per frame (20x20 image)
FIFO_DEPTH, 4, output word FIFO entries (power of 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
edge_in  input  1  edge decision bit from the hysteresis stage
edge_valid  input  1  readable strobe; edge_in is sampled when high
out_data  output  WORD_W  packed edge word; first pixel in bit 0
out_valid  output  1  out_data holds a valid word
out_ready  input  1  host accepts the word when out_valid && out_ready
frame_done  output  1  one-cycle pulse after the last word of a frame is accepted
overflow  output  1  sticky error flag
pix_count  output  9  pixels sampled so far in the current frame

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high, named clk and reset.
  - Reset has priority over every other event, including a transfer in progress.
- Reset values:
  - out_valid=0, out_data=0, frame_done=0, overflow=0, pix_count=0.
  - Shift register, bit counter and FIFO are emptied; state=COLLECT.
  - Any partial word or buffered words are discarded.
- State COLLECT:
  - On edge_valid=1, edge_in is written to bit position bit_cnt of the shift register; bit_cnt and pix_count increment.
  - A word completes when bit_cnt reaches WORD_W-1, or when the sampled pixel is pixel FRAME_PIX-1.
  - A last partial word is zero-padded in its upper bits.
  - The completed word is pushed to the FIFO in the same cycle and bit_cnt returns to 0.
  - After pixel FRAME_PIX-1 is sampled, pix_count resets to 0 and the state goes to DRAIN.
- State DRAIN:
  - Waits until the FIFO is empty, i.e. the last word has been accepted by the host.
  - Then goes to DONE.
  - edge_valid=1 during DRAIN: the bit is dropped, overflow is set, and no count changes.
- State DONE:
  - Lasts one cycle. frame_done=1 for that cycle, then the state returns to COLLECT.
  - edge_valid=1 in DONE is dropped and sets overflow.
- FIFO:
  - out_data/out_valid are driven from the FIFO head register.
  - A word completed in cycle N appears with out_valid=1 at cycle N+1 if the FIFO was empty (1-cycle latency).
  - out_data must stay stable while out_valid=1 and out_ready=0.
  - A pop occurs on out_valid && out_ready.
  - Simultaneous push and pop are legal in any fill state, including full (occupancy unchanged).
  - Push while full without a same-cycle pop: the word is dropped, overflow is set, and the counters still advance so frame alignment is kept.
  - Read and write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- overflow is cleared only by reset.
- Widths:
  - pix_count is 9 bits and saturates logically at FRAME_PIX-1 (never reaches 400).
  - bit_cnt is clog2(WORD_W) bits.

Test Plan:
- Reset then 8 pulses of edge_valid=1 with edge_in=1,0,1,1,0,0,0,1 -> one cycle after the 8th bit, out_valid=1 and out_data=8'h8D; pix_count=8.
- Full frame of 400 bits, all 1, with out_ready=1 constant -> 50 words of 8'hFF; frame_done pulses once, 2 cycles after the last word handshake completes; overflow=0.
- FRAME_PIX=20 build, 20 ones -> words 8'hFF, 8'hFF, 8'h0F (zero-padded); then DRAIN, DONE, back to COLLECT.
- out_ready=0 while 5 words (40 bits) arrive -> FIFO holds 4 words; 5th is dropped; overflow=1 and stays 1. Then raise out_ready -> the first 4 words come out in order, out_data stable during every stall.
- FIFO full with out_ready=1 and a word completing in the same cycle -> push and pop both occur, no overflow, occupancy stays 4.
- Assert reset mid-frame (pix_count=123, 2 words buffered) -> next cycle out_valid=0, pix_count=0, overflow=0; a new frame then packs from bit 0.
